booth_radix4_multiplier: RTL and testbench



---
 rtl/booth_radix4_multiplier_if.sv | 42 ++++
 rtl/booth_radix4_multiplier.sv | 114 +++++++++++
 tb/tb_booth_radix4_multiplier.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/booth_radix4_multiplier_if.sv
// Operand/handshake bundle for booth_radix4_multiplier.
// The abort signal exists only when BOOTH_ABORT_EN is defined.
interface booth_radix4_multiplier_if #(
  parameter int unsigned WIDTH = 16
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     result;
`ifdef BOOTH_ABORT_EN
  logic                   abort;
`endif

  modport master (
`ifdef BOOTH_ABORT_EN
    output abort,
`endif
    output start,
    output signed_mode,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
`ifdef BOOTH_ABORT_EN
    input  abort,
`endif
    input  start,
    input  signed_mode,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, two multiplier bits retired per cycle.
// Optional BOOTH_ABORT_EN adds an abort input that cancels a running operation.
module booth_radix4_multiplier #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH / 2 + 2)
) (
  input logic                      clk,
  input logic                      rst_n,
  booth_radix4_multiplier_if.slave bus
);
  localparam int unsigned E  = WIDTH + 2;
  localparam int unsigned AW = E + 2;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q, state_d;
  logic signed [AW-1:0] a_q, a_d;
  logic [E-1:0]         q_q, q_d;
  logic [E-1:0]         m_q, m_d;
  logic                 q_m1_q, q_m1_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic signed [AW-1:0] m_ext, pp, a_sum;
  logic [E-1:0]         ext_m, ext_q;
  logic                 accept;

  assign accept = bus.start && (state_q == StIdle || state_q == StDone);
  assign ext_m  = bus.signed_mode ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                  : {2'b00, bus.multiplicand};
  assign ext_q  = bus.signed_mode ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                  : {2'b00, bus.multiplier};

  // Two guard bits on A keep +/-2M representable for any E-bit M.
  assign m_ext = {{2{m_q[E-1]}}, m_q};

  always_comb begin
    pp = '0;
    case ({q_q[1:0], q_m1_q})
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext <<< 1;
      3'b100:         pp = -(m_ext <<< 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
  end

  assign a_sum = a_q + pp;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    q_d      = q_q;
    m_d      = m_q;
    q_m1_d   = q_m1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      state_d = StCalc;
      a_d     = '0;
      q_d     = ext_q;
      q_m1_d  = 1'b0;
      m_d     = ext_m;
      cnt_d   = CNT_W'(E / 2);
    end else begin
      case (state_q)
        StCalc: begin
`ifdef BOOTH_ABORT_EN
          if (bus.abort) begin
            state_d = StIdle;
          end else
`endif
          begin
            // Arithmetic shift of {A,Q,q_m1} right by two after the add.
            a_d    = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
            q_d    = {a_sum[1:0], q_q[E-1:2]};
            q_m1_d = q_q[1];
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state_d  = StDone;
              result_d = {a_d[WIDTH-3:0], q_d};
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      q_m1_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      q_q      <= q_d;
      m_q      <= m_d;
      q_m1_q   <= q_m1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == StCalc);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench: directed corner cases plus random operands against an
// integer-arithmetic product model. Abort checks build only with BOOTH_ABORT_EN.
module tb_booth_radix4_multiplier;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;

  booth_radix4_multiplier_if #(.WIDTH(W)) bus ();

  booth_radix4_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic sm, input logic [W-1:0] m,
                                        input logic [W-1:0] q);
    longint a, b;
    a = sm ? longint'($signed(m)) : longint'({48'd0, m});
    b = sm ? longint'($signed(q)) : longint'({48'd0, q});
    return 32'(a * b);
  endfunction

  // Called at a negedge: presents a request, lets edge 0 take it, then scrambles inputs.
  task automatic issue(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q);
    bus.start        = 1'b1;
    bus.signed_mode  = sm;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(posedge clk);
    @(negedge clk);
    bus.start        = 1'b0;
    bus.signed_mode  = 1'($urandom);
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
  endtask

  // Starts at the negedge after edge 0; returns at the negedge where done is seen.
  task automatic wait_done(input string tag, input logic [31:0] exp, input int poke_at);
    int edges = 0;
    int busy_cnt = 0;
    bit seen = 0;
    while (!seen && edges <= 30) begin
      if (bus.done) begin
        seen = 1;
      end else begin
        if (bus.busy) busy_cnt++;
        if (poke_at != 0 && edges == poke_at) begin
          bus.start        = 1'b1;
          bus.multiplicand = W'($urandom);
          bus.multiplier   = W'($urandom);
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        edges++;
      end
    end
    bus.start = 1'b0;
    check_val({tag, "_done"}, 64'(seen), 64'd1);
    check_val({tag, "_lat"}, 64'(edges), 64'd9);
    check_val({tag, "_busy"}, 64'(busy_cnt), 64'd9);
    check_val({tag, "_res"}, 64'(bus.result), 64'(exp));
  endtask

  task automatic run_op(input string tag, input logic sm, input logic [W-1:0] m,
                        input logic [W-1:0] q, input logic [31:0] exp, input int poke_at);
    @(negedge clk);
    issue(sm, m, q);
    wait_done(tag, exp, poke_at);
    @(negedge clk);
    check_val({tag, "_hold"}, 64'(bus.result), 64'(exp));
    check_val({tag, "_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic        sm;
    logic [W-1:0] m, q;
    logic [31:0] prev;
    bus.start        = 1'b0;
    bus.signed_mode  = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
`ifdef BOOTH_ABORT_EN
    bus.abort        = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_res", 64'(bus.result), 64'd0);
    rst_n = 1'b1;

    run_op("s_m3x7", 1'b1, 16'hFFFD, 16'd7, 32'hFFFFFFEB, 0);
    run_op("u_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
    run_op("s_ffff", 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 0);
    run_op("s_minmin", 1'b1, 16'h8000, 16'h8000, 32'h40000000, 0);
    run_op("s_minmax", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, 0);
    run_op("calc_start", 1'b0, 16'd1234, 16'd5678, 32'd7006652, 3);

    // Back-to-back: new request presented while done is high.
    @(negedge clk);
    issue(1'b0, 16'd300, 16'd200);
    wait_done("b2b_first", 32'd60000, 0);
    issue(1'b0, 16'd5, 16'd6);
    check_val("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done("b2b_second", 32'd30, 0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    issue(1'b1, 16'd77, 16'd99);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy", 64'(bus.busy), 64'd0);
    check_val("arst_done", 64'(bus.done), 64'd0);
    check_val("arst_res", 64'(bus.result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 1'b1, 16'd100, 16'hFF9C, 32'hFFFFD8F0, 0);

`ifdef BOOTH_ABORT_EN
    begin
      bit saw_done = 0;
      prev = model(1'b1, 16'd123, 16'hFFD3);
      run_op("pre_abort", 1'b1, 16'd123, 16'hFFD3, prev, 0);
      @(negedge clk);
      issue(1'b0, 16'd999, 16'd888);
      repeat (2) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check_val("abort_busy", 64'(bus.busy), 64'd0);
      check_val("abort_res", 64'(bus.result), 64'(prev));
      repeat (12) begin
        if (bus.done) saw_done = 1;
        @(negedge clk);
      end
      check_val("abort_nodone", 64'(saw_done), 64'd0);
    end
`endif

    for (int i = 0; i < 24; i++) begin
      sm = 1'($urandom);
      m  = W'($urandom);
      q  = W'($urandom);
      if (i % 8 == 1) m = 16'h8000;
      if (i % 8 == 2) q = 16'hFFFF;
      run_op($sformatf("rnd%0d", i), sm, m, q, model(sm, m, q), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
